// File: rtl/close_sched_pkg.sv
// close_sched_pkg: FSM state encoding, default sizing constants and the interval clamp
// shared by the close request scheduler and its arbiter.
package close_sched_pkg;

  typedef enum logic [1:0] {IDLE, OFFER, WAIT} state_t;

  localparam int DEF_NUM_SESSIONS = 3;
  localparam int DEF_MIN_INTERVAL = 30;
  localparam int DEF_MAX_INTERVAL = 60;

  // Full-width unsigned clamp; callers zero-extend into 64 bits so no interval is truncated.
  function automatic logic [63:0] clamp_interval(input logic [63:0] iv,
                                                 input logic [63:0] lo,
                                                 input logic [63:0] hi);
    if (iv < lo) return lo;
    if (iv > hi) return hi;
    return iv;
  endfunction

endpackage

// File: rtl/close_sched_rr_arb.sv
// close_sched_rr_arb: combinational round-robin pick of the first pending session at or
// after rr_ptr, wrapping at NUM_SESSIONS.
module close_sched_rr_arb
  import close_sched_pkg::*;
#(
  parameter int NUM_SESSIONS = DEF_NUM_SESSIONS,
  parameter int SID_W        = 3
) (
  input  logic [NUM_SESSIONS-1:0] pending,
  input  logic [SID_W-1:0]        rr_ptr,
  output logic                    grant_valid,
  output logic [SID_W-1:0]        grant_idx
);

  logic [2*NUM_SESSIONS-1:0] doubled;
  logic [NUM_SESSIONS-1:0]   rotated;
  int                        pick;

  // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the winner.
  always_comb begin
    doubled     = {pending, pending} >> rr_ptr;
    rotated     = doubled[NUM_SESSIONS-1:0];
    grant_valid = |pending;
    pick        = 0;
    for (int i = NUM_SESSIONS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        pick = int'(rr_ptr) + i;
        if (pick >= NUM_SESSIONS) pick = pick - NUM_SESSIONS;
      end
    end
    grant_idx = SID_W'(pick);
  end

endmodule

// File: rtl/close_request_scheduler.sv
// close_request_scheduler: collects per-session close requests, clamps their intervals and
// issues them one at a time, round-robin, to the close timer. CLOSE_SCHED_STATS_EN adds counters.
module close_request_scheduler
  import close_sched_pkg::*;
#(
  parameter int NUM_SESSIONS = DEF_NUM_SESSIONS,
  parameter int SID_W        = 3,
  parameter int INTERVAL_W   = 32,
  parameter int MIN_INTERVAL = DEF_MIN_INTERVAL,
  parameter int MAX_INTERVAL = DEF_MAX_INTERVAL,
  parameter int WAIT_GUARD   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [SID_W-1:0]        req_sid,
  input  logic [INTERVAL_W-1:0]   req_interval,
  output logic                    req_ready,
  output logic                    out_valid,
  output logic [SID_W-1:0]        out_sid,
  output logic [INTERVAL_W-1:0]   out_interval,
  input  logic                    out_ready,
  input  logic [NUM_SESSIONS-1:0] closed_in,
  output logic [NUM_SESSIONS-1:0] pending_mask,
  output logic                    all_closed,
  output logic                    err_dup,
  output logic                    err_bad_sid,
`ifdef CLOSE_SCHED_STATS_EN
  output logic [15:0]             issued_cnt,
  output logic [15:0]             dropped_cnt,
`endif
  output logic                    err_timeout
);

  localparam logic [INTERVAL_W:0] GUARD_P1 = (INTERVAL_W + 1)'(WAIT_GUARD + 1);
  localparam logic [INTERVAL_W:0] CNT_ONE  = {{INTERVAL_W{1'b0}}, 1'b1};

  state_t                  state;
  logic [NUM_SESSIONS-1:0] pending, issued, closed;
  logic [INTERVAL_W-1:0]   interval_mem [NUM_SESSIONS];
  logic [SID_W-1:0]        rr_ptr;
  logic [INTERVAL_W:0]     wait_cnt;

  logic                    take, sid_ok, is_dup, accept, drop;
  logic                    handshake, close_hit, timeout;
  logic [NUM_SESSIONS-1:0] req_onehot, out_onehot;
  logic [INTERVAL_W-1:0]   clamped, grant_iv;
  logic [INTERVAL_W:0]     cnt_next, wait_limit;
  logic [SID_W-1:0]        next_ptr, grant_idx;
  logic                    grant_valid;

  assign req_ready    = ~rst;
  assign pending_mask = pending;

  // ---- request intake: range check, duplicate check, clamp ----
  assign take       = req_valid & req_ready;
  assign sid_ok     = int'(req_sid) < NUM_SESSIONS;
  assign req_onehot = NUM_SESSIONS'(1) << req_sid;
  assign is_dup     = |(req_onehot & (pending | issued | closed));
  assign accept     = take & sid_ok & ~is_dup;
  assign drop       = take & ~accept;
  assign clamped    = INTERVAL_W'(clamp_interval(64'(req_interval), 64'(MIN_INTERVAL),
                                                 64'(MAX_INTERVAL)));

  close_sched_rr_arb #(
    .NUM_SESSIONS (NUM_SESSIONS),
    .SID_W        (SID_W)
  ) u_arb (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    grant_iv = '0;
    for (int i = 0; i < NUM_SESSIONS; i++)
      if (grant_idx == SID_W'(i)) grant_iv = interval_mem[i];
  end

  // ---- issue / wait bookkeeping ----
  assign out_onehot = NUM_SESSIONS'(1) << out_sid;
  assign handshake  = (state == OFFER) & out_valid & out_ready;
  assign close_hit  = (state == WAIT) & |(out_onehot & closed_in);
  assign cnt_next   = (&wait_cnt) ? wait_cnt : wait_cnt + CNT_ONE;
  assign wait_limit = {1'b0, out_interval} + GUARD_P1;
  assign timeout    = (state == WAIT) & ~close_hit & (cnt_next >= wait_limit);
  assign next_ptr   = (int'(out_sid) >= NUM_SESSIONS - 1) ? '0 : SID_W'(int'(out_sid) + 1);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SESSIONS; i++)
      if (accept && req_sid == SID_W'(i)) interval_mem[i] <= clamped;
  end

  // A session is never pending and issued at once, so set/clear masks never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      issued      <= '0;
      closed      <= '0;
      all_closed  <= 1'b0;
      err_dup     <= 1'b0;
      err_bad_sid <= 1'b0;
    end else begin
      pending     <= (pending & ~(handshake ? out_onehot : '0))
                   | (accept ? req_onehot : '0) | (timeout ? out_onehot : '0);
      issued      <= (issued | (handshake ? out_onehot : '0)) & ~(timeout ? out_onehot : '0);
      closed      <= closed | (close_hit ? out_onehot : '0);
      all_closed  <= &closed;
      err_dup     <= take & sid_ok & is_dup;
      err_bad_sid <= take & ~sid_ok;
    end
  end

  // ---- FSM: IDLE picks, OFFER holds until taken, WAIT for close or guard expiry ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      out_sid      <= '0;
      out_interval <= '0;
      rr_ptr       <= '0;
      wait_cnt     <= '0;
      err_timeout  <= 1'b0;
    end else begin
      err_timeout <= timeout;
      case (state)
        IDLE: begin
          if (grant_valid && !all_closed) begin
            out_sid      <= grant_idx;
            out_interval <= grant_iv;
            out_valid    <= 1'b1;
            state        <= OFFER;
          end
        end
        OFFER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            wait_cnt  <= CNT_ONE;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (close_hit || timeout) state <= IDLE;
          else wait_cnt <= cnt_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLOSE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (handshake && issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
      if (drop && dropped_cnt != 16'hFFFF) dropped_cnt <= dropped_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_close_request_scheduler.sv
// Bench for close_request_scheduler: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a timestamp-based behavioural model.
module tb_close_request_scheduler;

  localparam int N = 3, SW = 3, IW = 32, MINI = 30, MAXI = 60, GUARD = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1, req_valid = 1'b0, out_ready = 1'b0;
  logic [SW-1:0] req_sid = '0;
  logic [IW-1:0] req_interval = '0;
  logic [N-1:0]  closed_in = '0;
  logic          req_ready, out_valid, all_closed, err_dup, err_bad_sid, err_timeout;
  logic [SW-1:0] out_sid;
  logic [IW-1:0] out_interval;
  logic [N-1:0]  pending_mask;

  int checks = 0, errors = 0;
  int tally_dup = 0, tally_bad = 0;
  int tally_issue [N] = '{default: 0};

  always #5 clk = ~clk;

  close_request_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sid(req_sid),
    .req_interval(req_interval), .req_ready(req_ready), .out_valid(out_valid),
    .out_sid(out_sid), .out_interval(out_interval), .out_ready(out_ready),
    .closed_in(closed_in), .pending_mask(pending_mask), .all_closed(all_closed),
    .err_dup(err_dup), .err_bad_sid(err_bad_sid), .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sessions are tracked as sets; the WAIT deadline is an absolute edge number.
  bit                m_live = 0;
  longint            edge_no = 0, m_hs = 0;
  int                m_phase = 0, m_rr = 0, m_sid = 0;
  bit [N-1:0]        m_pend = '0, m_iss = '0, m_cls = '0;
  bit                m_ov = 0, m_allc = 0, m_edup = 0, m_ebad = 0, m_eto = 0;
  longint unsigned   m_iv = 0;
  longint unsigned   m_ivmem [N];

  function automatic longint unsigned model_clamp(input longint unsigned v);
    if (v < MINI) return MINI;
    if (v > MAXI) return MAXI;
    return v;
  endfunction

  task automatic model_step();
    bit [N-1:0] p, is, c;
    bit nd, nb, nt;
    int s, pick;
    edge_no++;
    if (rst) begin
      m_live = 1; m_pend = '0; m_iss = '0; m_cls = '0; m_ov = 0; m_sid = 0; m_iv = 0;
      m_allc = 0; m_edup = 0; m_ebad = 0; m_eto = 0; m_phase = 0; m_rr = 0;
      return;
    end
    p = m_pend; is = m_iss; c = m_cls; nd = 0; nb = 0; nt = 0;
    if (req_valid) begin
      s = int'(req_sid);
      if (s >= N) nb = 1;
      else if (m_pend[s] || m_iss[s] || m_cls[s]) nd = 1;
      else begin
        p[s] = 1;
        m_ivmem[s] = model_clamp(longint'(req_interval));
      end
    end
    if (m_phase == 0) begin
      pick = -1;
      for (int i = 0; i < N; i++)
        if (pick < 0 && m_pend[(m_rr + i) % N]) pick = (m_rr + i) % N;
      if (!m_allc && pick >= 0) begin
        m_sid = pick; m_iv = m_ivmem[pick]; m_ov = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (out_ready) begin
        p[m_sid] = 0; is[m_sid] = 1; m_ov = 0; m_rr = (m_sid + 1) % N;
        m_hs = edge_no; m_phase = 2;
      end
    end else begin
      if (closed_in[m_sid]) begin
        c[m_sid] = 1; m_phase = 0;
      end else if (edge_no == m_hs + longint'(m_iv) + GUARD) begin
        nt = 1; is[m_sid] = 0; p[m_sid] = 1; m_phase = 0;
      end
    end
    m_allc = &m_cls;
    m_pend = p; m_iss = is; m_cls = c;
    m_edup = nd; m_ebad = nb; m_eto = nt;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle after the first reset, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("req_ready", req_ready, !rst);
      chk("out_valid", out_valid, m_ov);
      chk("out_sid", out_sid, m_sid);
      chk("out_interval", out_interval, m_iv);
      chk("pending_mask", pending_mask, m_pend);
      chk("all_closed", all_closed, m_allc);
      chk("err_dup", err_dup, m_edup);
      chk("err_bad_sid", err_bad_sid, m_ebad);
      chk("err_timeout", err_timeout, m_eto);
      if (err_dup === 1'b1) tally_dup++;
      if (err_bad_sid === 1'b1) tally_bad++;
      if (out_valid === 1'b1 && out_ready === 1'b1 && int'(out_sid) < N) tally_issue[out_sid]++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 0; out_ready = 0; closed_in = '0;
    step();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_all_closed", all_closed, 0);
    step();
    rst = 0;
  endtask

  task automatic send(input int sid, input logic [IW-1:0] iv);
    req_valid = 1; req_sid = SW'(sid); req_interval = iv;
    step();
    req_valid = 0;
  endtask

  task automatic wait_out(output bit ok, output logic [SW-1:0] sid, output logic [IW-1:0] iv);
    ok = 0; sid = '0; iv = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ok = 1; sid = out_sid; iv = out_interval;
        break;
      end
    end
    chk("wait_out_seen", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit            ok;
    logic [SW-1:0] sid;
    logic [IW-1:0] iv;
    int            k, d0, b0, i0;
    int            order [3] = '{2, 0, 1};

    // 1: clamp up to MIN, two-cycle latency
    do_reset();
    send(1, 10);
    @(negedge clk); chk("t1_not_yet", out_valid, 0);
    step();
    @(negedge clk);
    chk("t1_valid", out_valid, 1); chk("t1_sid", out_sid, 1); chk("t1_iv", out_interval, 30);
    out_ready = 1; step(); out_ready = 0; closed_in = 3'b010;
    step(); step();

    // 2: clamp down to MAX, outputs held while ready is low
    do_reset();
    send(0, 100);
    step();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t2_hold_valid", out_valid, 1); chk("t2_hold_sid", out_sid, 0);
      chk("t2_hold_iv", out_interval, 60);
      step();
    end
    out_ready = 1; step(); out_ready = 0;
    @(negedge clk);
    chk("t2_taken", out_valid, 0); chk("t2_pending_clear", pending_mask, 0);

    // 3: timeout of sid 1 leaves rr_ptr=2 with all three pending -> order 2,0,1
    do_reset();
    out_ready = 1;
    send(1, 10);
    step(); step(); step();
    send(0, 35); send(2, 50);
    ok = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin ok = 1; break; end
    end
    chk("t3_timeout_seen", ok, 1);
    for (int j = 0; j < 3; j++) begin
      wait_out(ok, sid, iv);
      chk("t3_order", sid, order[j]);
      step();
      closed_in[sid] = 1'b1;
    end
    step(); step(); step();
    @(negedge clk); chk("t3_all_closed", all_closed, 1);
    send(0, 30);
    @(negedge clk); chk("t3_dup_after_all", err_dup, 1);
    step(); step();
    @(negedge clk); chk("t3_no_issue", out_valid, 0);

    // 4: duplicate and out-of-range requests
    do_reset();
    out_ready = 1; closed_in = 3'b010;
    d0 = tally_dup; b0 = tally_bad; i0 = tally_issue[1];
    send(1, 20); send(1, 20);
    @(negedge clk); chk("t4_dup_pulse", err_dup, 1);
    send(5, 20);
    @(negedge clk); chk("t4_bad_pulse", err_bad_sid, 1);
    for (int j = 0; j < 40; j++) step();
    chk("t4_dup_count", tally_dup - d0, 1);
    chk("t4_bad_count", tally_bad - b0, 1);
    chk("t4_issue_count", tally_issue[1] - i0, 1);

    // 5: guard expiry 46 cycles after the handshake, then re-offer
    do_reset();
    out_ready = 1;
    send(2, 40);
    wait_out(ok, sid, iv);
    chk("t5_sid", sid, 2); chk("t5_iv", iv, 40);
    k = 0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin k = j; break; end
    end
    chk("t5_timeout_cycle", k, 46);
    chk("t5_repending", pending_mask, 3'b100);
    wait_out(ok, sid, iv);
    chk("t5_reoffer_sid", sid, 2);

    // 6: reset while waiting drops everything
    do_reset();
    out_ready = 1;
    send(0, 45);
    wait_out(ok, sid, iv);
    step(); step();
    send(2, 33);
    rst = 1; step();
    @(negedge clk);
    chk("t6_valid", out_valid, 0); chk("t6_pending", pending_mask, 0);
    chk("t6_all_closed", all_closed, 0);
    rst = 0;
    send(1, 10);
    step();
    @(negedge clk);
    chk("t6_fresh_valid", out_valid, 1); chk("t6_fresh_sid", out_sid, 1);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 399) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_sid   = SW'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0:       req_interval = IW'($urandom_range(0, 100));
        1:       req_interval = IW'($urandom);
        2:       req_interval = IW'($urandom_range(28, 32));
        default: req_interval = IW'($urandom_range(58, 62));
      endcase
      out_ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 19) == 0) closed_in = N'($urandom);
      step();
    end
    rst = 0; req_valid = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
